exec_unit: RTL and testbench
============================

// Module: exec_unit
// PURPOSE
//  Parametrised multi-cycle execute unit: ALU, shifter, iterative multiplier and divider behind one start/done handshake.
//  Next-generation replacement for the core's inline EXECUTE ALU and its separate mul/div instances.
//  Produces correct Z/C/V/N flags per op, including true signed overflow.
//  Signals errors for divide-by-zero and illegal opcodes.
// PARAMETERS
//  WIDTH  16  operand width; power of two, >= 8
//  STEP   4   mul/div bits retired per RUN cycle; must divide WIDTH
// PORTS
//  clk        in   1        clock, all state on rising edge
//  reset      in   1        asynchronous, active-high reset
//  start      in   1        request; sampled only in IDLE or DONE
//  op         in   4        0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT,6 NEG,7 SHL,8 SHR,9 SAR,10 MUL,11 IMUL,12 DIV,13 IDIV,14-15 illegal
//  a          in   WIDTH    operand 1 (dividend / shift source)
//  b          in   WIDTH    operand 2 (divisor / shift amount in b[log2(WIDTH)-1:0])
//  busy       out  1        high in RUN and FIX
//  done       out  1        one-cycle pulse; results valid from this cycle
//  result_lo  out  WIDTH    result / product low / quotient
//  result_hi  out  WIDTH    product high / remainder; 0 for single-cycle ops
//  flags      out  4        [3]Z [2]C [1]V [0]N
//  err        out  1        div-by-zero or illegal op; valid with done
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, err=0, flags=0, result_lo=0, result_hi=0. Reset mid-operation aborts, no done.
//  FSM: IDLE -start-> single-cycle op: DONE; MUL/IMUL/DIV/IDIV: RUN. RUN holds WIDTH/STEP cycles -> FIX (1 cycle) -> DONE.
//   DONE lasts 1 cycle -> IDLE. start in DONE is accepted as in IDLE (back-to-back ops).
//  Latency: start high at edge N -> done high after edge N+1 (single-cycle) or N+WIDTH/STEP+2 (mul/div).
//  a, b, op latched on accept; input changes during busy have no effect; start ignored while busy.
//  Outputs hold last values until the next done; flags/err update only with done.
//  ADD/SUB: C = carry-out / borrow; V = signed overflow (operands same sign for ADD, differing for SUB; result sign differs from a).
//  NEG: result = 0-a, C = (a!=0), V = (a==MIN).
//  AND/OR/XOR/NOT: C=0, V=0.
//  SHL/SHR/SAR: C = last bit shifted out; shift 0 -> result=a, C=0; V=0.
//  MUL/IMUL: {result_hi,result_lo} = a*b unsigned/signed over 2*WIDTH bits.
//   Z = (full product==0); N = product msb (IMUL) or 0 (MUL); C=V=0.
//  DIV/IDIV: result_lo=quotient, result_hi=remainder.
//   IDIV truncates toward zero, remainder takes dividend sign; sign fixup in FIX.
//   b==0: result_lo=all ones, result_hi=a, err=1, Z=0, C=V=N=0.
//   IDIV MIN/-1: result_lo=MIN, result_hi=0, V=1.
//  Default Z = (result_lo==0); default N = result_lo[WIDTH-1]. DIV: N=0.
//  Illegal op (14-15): 1-cycle path; results 0, flags 0, err=1.
// TESTING
//  ADD a=7FFF b=0001 -> done 1 cycle after start, result_lo=8000, flags Z0 C0 V1 N1; SUB 0000-0001 -> FFFF, C1 V0 N1.
//  IMUL a=FFFE b=0003 (W16,S4) -> done 6 cycles after start, {hi,lo}=FFFF_FFFA, N1 Z0; MUL FFFF*FFFF -> FFFE_0001.
//  IDIV a=FFF9(-7) b=0002 -> result_lo=FFFD(-3), result_hi=FFFF(-1); DIV 0064/0000 -> lo=FFFF, hi=0064, err=1.
//  SAR a=8001 b=0001 -> C000, C1 N1; SHL b=0 -> result=a, C0; op=15 -> err=1, results 0.
//  start held high through busy and a/b changed mid-RUN -> single done, result from latched operands;
//   back-to-back start in DONE accepted.
//  reset asserted mid-RUN -> outputs all 0 immediately, no done; next op after release correct; repeat with WIDTH=32, STEP=8.

Source files
------------

// File: rtl/exec_if.sv
// Request/response bundle for the execute unit: operands and start in,
// busy/done handshake, results, flags and error out.
interface exec_if #(parameter int WIDTH = 16);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic [3:0]       flags;
   logic             err;

   modport master (output start, op, a, b,
                   input  busy, done, result_lo, result_hi, flags, err);
   modport slave  (input  start, op, a, b,
                   output busy, done, result_lo, result_hi, flags, err);
endinterface

// File: rtl/exec_unit.sv
// Multi-cycle execute unit: single-cycle ALU/shifter plus an iterative
// STEP-bits-per-cycle multiplier and restoring divider sharing one datapath.
module exec_unit #(
   parameter int WIDTH = 16,
   parameter int STEP  = 4
) (
   input  logic clk,
   input  logic reset,
   exec_if.slave bus
);
   localparam int SW   = $clog2(WIDTH);
   localparam int NCYC = WIDTH / STEP;
   localparam int CW   = $clog2(NCYC) + 1;
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                          OP_XOR = 4'd4, OP_NOT = 4'd5, OP_NEG = 4'd6, OP_SHL = 4'd7,
                          OP_SHR = 4'd8, OP_SAR = 4'd9, OP_MUL = 4'd10, OP_IMUL = 4'd11,
                          OP_DIV = 4'd12, OP_IDIV = 4'd13;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           st, st_nx;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, dvs_q, acc_hi, acc_lo, hi_nx, lo_nx;
   logic             neg_q, rneg_q, dz_q, ovf_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] res_lo, res_hi;
   logic [3:0]       flg;
   logic             err_r;

   logic             accept, multi, sgn;
   logic [WIDTH-1:0] abs_a, abs_b;

   assign accept = (st == IDLE || st == DONE) && bus.start;
   assign multi  = bus.op inside {OP_MUL, OP_IMUL, OP_DIV, OP_IDIV};
   assign sgn    = (bus.op == OP_IMUL) || (bus.op == OP_IDIV);
   // Iterative engines work on magnitudes; signs are restored in FIX.
   assign abs_a  = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign abs_b  = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   assign bus.busy      = (st == RUN) || (st == FIX);
   assign bus.done      = (st == DONE);
   assign bus.result_lo = res_lo;
   assign bus.result_hi = res_hi;
   assign bus.flags     = flg;
   assign bus.err       = err_r;

   always_comb begin
      st_nx = st;
      case (st)
         IDLE, DONE: begin
            if (bus.start) st_nx = multi ? RUN : DONE;
            else           st_nx = IDLE;
         end
         RUN:     if (cnt == CW'(NCYC - 1)) st_nx = FIX;
         FIX:     st_nx = DONE;
         default: st_nx = IDLE;
      endcase
   end

   // Single-cycle ops evaluate straight from the inputs at the accept edge.
   logic [WIDTH:0]   sum, shl_w, shr_w, sar_w;
   logic [SW-1:0]    sh;
   logic [WIDTH-1:0] alu_lo;
   logic [3:0]       alu_fl;
   logic             alu_c, alu_v, alu_err;

   always_comb begin
      sh      = bus.b[SW-1:0];
      sum     = '0;
      shl_w   = {1'b0, bus.a} << sh;
      shr_w   = {bus.a, 1'b0} >> sh;
      sar_w   = $unsigned($signed({bus.a, 1'b0}) >>> sh);
      alu_lo  = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      alu_fl  = '0;
      case (bus.op)
         OP_ADD: begin
            sum    = {1'b0, bus.a} + {1'b0, bus.b};
            alu_lo = sum[WIDTH-1:0];
            alu_c  = sum[WIDTH];
            alu_v  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_lo[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            sum    = {1'b0, bus.a} - {1'b0, bus.b};
            alu_lo = sum[WIDTH-1:0];
            alu_c  = sum[WIDTH];
            alu_v  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_lo[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND: alu_lo = bus.a & bus.b;
         OP_OR:  alu_lo = bus.a | bus.b;
         OP_XOR: alu_lo = bus.a ^ bus.b;
         OP_NOT: alu_lo = ~bus.a;
         OP_NEG: begin
            alu_lo = -bus.a;
            alu_c  = (bus.a != '0);
            alu_v  = (bus.a == MIN);
         end
         // The extra guard bit catches the last bit shifted out; zero for sh==0.
         OP_SHL: begin alu_lo = shl_w[WIDTH-1:0]; alu_c = shl_w[WIDTH]; end
         OP_SHR: begin alu_lo = shr_w[WIDTH:1];   alu_c = shr_w[0];     end
         OP_SAR: begin alu_lo = sar_w[WIDTH:1];   alu_c = sar_w[0];     end
         OP_MUL, OP_IMUL, OP_DIV, OP_IDIV: alu_lo = '0;
         default: alu_err = 1'b1;
      endcase
      if (!alu_err) alu_fl = {alu_lo == '0, alu_c, alu_v, alu_lo[WIDTH-1]};
   end

   // One RUN cycle: STEP multiplier digits or STEP quotient bits.
   logic [WIDTH+STEP-1:0] part;
   logic [WIDTH:0]        rem;

   always_comb begin
      hi_nx = acc_hi;
      lo_nx = acc_lo;
      part  = '0;
      rem   = '0;
      if (op_q == OP_MUL || op_q == OP_IMUL) begin
         part  = {{STEP{1'b0}}, acc_hi} +
                 ({{STEP{1'b0}}, dvs_q} * {{WIDTH{1'b0}}, acc_lo[STEP-1:0]});
         hi_nx = part[WIDTH+STEP-1:STEP];
         lo_nx = {part[STEP-1:0], acc_lo[WIDTH-1:STEP]};
      end else begin
         for (int i = 0; i < STEP; i++) begin
            rem   = {hi_nx, lo_nx[WIDTH-1]};
            lo_nx = {lo_nx[WIDTH-2:0], 1'b0};
            if (rem >= {1'b0, dvs_q}) begin
               rem      = rem - {1'b0, dvs_q};
               lo_nx[0] = 1'b1;
            end
            hi_nx = rem[WIDTH-1:0];
         end
      end
   end

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rmd, fix_lo, fix_hi;
   logic [3:0]         fix_fl;
   logic               fix_err;

   always_comb begin
      prod = {acc_hi, acc_lo};
      if (op_q == OP_IMUL && neg_q) prod = -prod;
      quo = acc_lo;
      rmd = acc_hi;
      if (op_q == OP_IDIV) begin
         if (neg_q)  quo = -quo;
         if (rneg_q) rmd = -rmd;
      end
      fix_lo  = quo;
      fix_hi  = rmd;
      fix_fl  = {quo == '0, 1'b0, ovf_q, (op_q == OP_IDIV) & quo[WIDTH-1]};
      fix_err = 1'b0;
      if (op_q == OP_MUL || op_q == OP_IMUL) begin
         fix_lo = prod[WIDTH-1:0];
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_fl = {prod == '0, 2'b00, (op_q == OP_IMUL) & prod[2*WIDTH-1]};
      end else if (dz_q) begin
         fix_lo  = '1;
         fix_hi  = a_q;
         fix_fl  = '0;
         fix_err = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st     <= IDLE;
         op_q   <= '0;
         a_q    <= '0;
         dvs_q  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
         ovf_q  <= 1'b0;
         res_lo <= '0;
         res_hi <= '0;
         flg    <= '0;
         err_r  <= 1'b0;
      end else begin
         st <= st_nx;
         if (accept) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            dvs_q  <= abs_b;
            acc_hi <= '0;
            acc_lo <= abs_a;
            cnt    <= '0;
            neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            rneg_q <= bus.a[WIDTH-1];
            dz_q   <= (bus.b == '0);
            ovf_q  <= (bus.op == OP_IDIV) && (bus.a == MIN) && (bus.b == '1);
            if (!multi) begin
               res_lo <= alu_lo;
               res_hi <= '0;
               flg    <= alu_fl;
               err_r  <= alu_err;
            end
         end else if (st == RUN) begin
            acc_hi <= hi_nx;
            acc_lo <= lo_nx;
            cnt    <= cnt + 1'b1;
         end else if (st == FIX) begin
            res_lo <= fix_lo;
            res_hi <= fix_hi;
            flg    <= fix_fl;
            err_r  <= fix_err;
         end
      end
   end
endmodule

// File: tb/tb_exec_unit.sv
// Randomised bench for exec_unit at W16/S4 and W32/S8 against an arithmetic
// reference model built on 64-bit integer math.
module tb_exec_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   exec_if #(.WIDTH(16)) if16();
   exec_if #(.WIDTH(32)) if32();

   exec_unit #(.WIDTH(16), .STEP(4)) u16 (.clk(clk), .reset(reset), .bus(if16));
   exec_unit #(.WIDTH(32), .STEP(8)) u32 (.clk(clk), .reset(reset), .bus(if32));

   typedef struct {
      logic [63:0] lo;
      logic [63:0] hi;
      logic [3:0]  fl;
      logic        err;
   } res_t;

   typedef struct {
      int          u;
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;

   function automatic int wid(int u);
      return (u != 0) ? 32 : 16;
   endfunction

   function automatic int exp_lat(int u, logic [3:0] op);
      if (op >= 4'd10 && op <= 4'd13) return (u != 0) ? 32/8 + 2 : 16/4 + 2;
      return 1;
   endfunction

   function automatic longint sx(logic [63:0] x, int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      x = x & m;
      if (x[w-1]) return longint'(x) - (longint'(1) << w);
      return longint'(x);
   endfunction

   // Reference: results from plain integer arithmetic on the operand values.
   function automatic res_t model(int w, logic [3:0] op, logic [63:0] a, logic [63:0] b);
      res_t r;
      logic [63:0] m, mn, t, p;
      longint sa, sb, sr, hmax, hmin;
      int sh;
      logic c, v, alu;
      m = (64'd1 << w) - 64'd1;
      mn = 64'd1 << (w - 1);
      a = a & m; b = b & m;
      sa = sx(a, w); sb = sx(b, w);
      hmax = (longint'(1) << (w - 1)) - 1;
      hmin = -(longint'(1) << (w - 1));
      sh = int'(b & 64'(w - 1));
      r.lo = 0; r.hi = 0; r.fl = 0; r.err = 0;
      c = 0; v = 0; alu = 1;
      case (op)
         4'd0: begin t = a + b; r.lo = t & m; c = t[w]; sr = sa + sb; v = (sr > hmax) || (sr < hmin); end
         4'd1: begin r.lo = (a - b) & m; c = (a < b); sr = sa - sb; v = (sr > hmax) || (sr < hmin); end
         4'd2: r.lo = a & b;
         4'd3: r.lo = a | b;
         4'd4: r.lo = a ^ b;
         4'd5: r.lo = ~a & m;
         4'd6: begin r.lo = (64'd0 - a) & m; c = (a != 0); v = (a == mn); end
         4'd7: begin r.lo = (a << sh) & m; c = (sh != 0) ? a[w - sh] : 1'b0; end
         4'd8: begin r.lo = a >> sh; c = (sh != 0) ? a[sh - 1] : 1'b0; end
         4'd9: begin r.lo = 64'(sa >>> sh) & m; c = (sh != 0) ? a[sh - 1] : 1'b0; end
         4'd10, 4'd11: begin
            alu = 0;
            if (op == 4'd10) p = a * b;
            else begin
               p = 64'(sa * sb);
               if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
            end
            r.lo = p & m;
            r.hi = (p >> w) & m;
            r.fl = {p == 0, 2'b00, (op == 4'd11) ? p[2*w-1] : 1'b0};
         end
         4'd12, 4'd13: begin
            alu = 0;
            if (b == 0) begin
               r.lo = m; r.hi = a; r.err = 1;
            end else if (op == 4'd12) begin
               r.lo = a / b; r.hi = a % b;
               r.fl = {r.lo == 0, 3'b000};
            end else if (a == mn && sb == -1) begin
               r.lo = mn; r.hi = 0;
               r.fl = 4'b0011;
            end else begin
               r.lo = 64'(sa / sb) & m;
               r.hi = 64'(sa % sb) & m;
               r.fl = {r.lo == 0, 2'b00, r.lo[w-1]};
            end
         end
         default: begin alu = 0; r.err = 1; end
      endcase
      if (alu) r.fl = {r.lo == 0, c, v, r.lo[w-1]};
      return r;
   endfunction

   task automatic drive(int u, logic st, logic [3:0] op, logic [63:0] a, logic [63:0] b);
      if (u == 0) begin if16.start = st; if16.op = op; if16.a = a[15:0]; if16.b = b[15:0]; end
      else        begin if32.start = st; if32.op = op; if32.a = a[31:0]; if32.b = b[31:0]; end
   endtask

   function automatic logic dn(int u);
      return (u != 0) ? if32.done : if16.done;
   endfunction

   function automatic res_t grab(int u);
      res_t r;
      if (u == 0) begin r.lo = 64'(if16.result_lo); r.hi = 64'(if16.result_hi); r.fl = if16.flags; r.err = if16.err; end
      else        begin r.lo = 64'(if32.result_lo); r.hi = 64'(if32.result_hi); r.fl = if32.flags; r.err = if32.err; end
      return r;
   endfunction

   function automatic logic [63:0] rnd(int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 6))
         0: return 64'd0;
         1: return 64'd1 << (w - 1);
         2: return m;
         3: return 64'd1;
         default: return {$urandom, $urandom} & m;
      endcase
   endfunction

   // Called just after a rising edge; returns once done is seen or the bound runs out.
   // Operands are scrambled after acceptance so only latched values can matter.
   task automatic do_op(input int u, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit hold, output res_t r, output int lat);
      bit seen;
      drive(u, 1'b1, op, a, b);
      lat = 0; seen = 0;
      while (!seen && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         drive(u, hold, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
         if (dn(u)) seen = 1;
      end
      drive(u, 1'b0, 4'd0, 64'd0, 64'd0);
      r = grab(u);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(0, 1'b0, 4'd0, 64'd0, 64'd0);
      drive(1, 1'b0, 4'd0, 64'd0, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({if16.busy, if16.done, if16.err, if16.flags, if16.result_lo, if16.result_hi} !== '0) begin
         miscompares++;
         $display("FAIL reset16: busy=%b done=%b err=%b flags=%b lo=%h hi=%h, expected all 0",
                  if16.busy, if16.done, if16.err, if16.flags, if16.result_lo, if16.result_hi);
      end
      vectors++;
      if ({if32.busy, if32.done, if32.err, if32.flags, if32.result_lo, if32.result_hi} !== '0) begin
         miscompares++;
         $display("FAIL reset32: busy=%b done=%b err=%b flags=%b lo=%h hi=%h, expected all 0",
                  if32.busy, if32.done, if32.err, if32.flags, if32.result_lo, if32.result_hi);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      vec_t dv [16];
      res_t got, e;
      int lat;
      dv[0]  = '{0, 4'd0,  64'h7fff, 64'h0001};
      dv[1]  = '{0, 4'd1,  64'h0000, 64'h0001};
      dv[2]  = '{0, 4'd11, 64'hfffe, 64'h0003};
      dv[3]  = '{0, 4'd10, 64'hffff, 64'hffff};
      dv[4]  = '{0, 4'd13, 64'hfff9, 64'h0002};
      dv[5]  = '{0, 4'd12, 64'h0064, 64'h0000};
      dv[6]  = '{0, 4'd9,  64'h8001, 64'h0001};
      dv[7]  = '{0, 4'd7,  64'h1234, 64'h0000};
      dv[8]  = '{0, 4'd15, 64'h1234, 64'h5678};
      dv[9]  = '{0, 4'd13, 64'h8000, 64'hffff};
      dv[10] = '{0, 4'd6,  64'h8000, 64'h0000};
      dv[11] = '{0, 4'd13, 64'h8001, 64'h0000};
      dv[12] = '{1, 4'd11, 64'hfffffffe, 64'h00000003};
      dv[13] = '{1, 4'd13, 64'h80000000, 64'hffffffff};
      dv[14] = '{1, 4'd7,  64'h00000003, 64'h0000001f};
      dv[15] = '{1, 4'd14, 64'h0, 64'h0};
      foreach (dv[i]) begin
         do_op(dv[i].u, dv[i].op, dv[i].a, dv[i].b, 1'b0, got, lat);
         e = model(wid(dv[i].u), dv[i].op, dv[i].a, dv[i].b);
         vectors++;
         if (got.lo !== e.lo || got.hi !== e.hi || got.fl !== e.fl || got.err !== e.err ||
             lat != exp_lat(dv[i].u, dv[i].op)) begin
            miscompares++;
            $display("FAIL directed[%0d] op=%0d a=%h b=%h: got lo=%h hi=%h fl=%b err=%b lat=%0d, want lo=%h hi=%h fl=%b err=%b lat=%0d",
                     i, dv[i].op, dv[i].a, dv[i].b, got.lo, got.hi, got.fl, got.err, lat,
                     e.lo, e.hi, e.fl, e.err, exp_lat(dv[i].u, dv[i].op));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random(int n);
      res_t got, e;
      int lat, u;
      logic [3:0] op;
      logic [63:0] a, b;
      for (int i = 0; i < n; i++) begin
         u  = i % 2;
         op = 4'($urandom_range(0, 15));
         a  = rnd(wid(u));
         b  = rnd(wid(u));
         if (op >= 4'd7 && op <= 4'd9 && $urandom_range(0, 1) == 1) b = 64'($urandom_range(0, wid(u) - 1));
         do_op(u, op, a, b, 1'b0, got, lat);
         e = model(wid(u), op, a, b);
         vectors++;
         if (got.lo !== e.lo || got.hi !== e.hi || got.fl !== e.fl || got.err !== e.err ||
             lat != exp_lat(u, op)) begin
            miscompares++;
            $display("FAIL random[%0d] w=%0d op=%0d a=%h b=%h: got lo=%h hi=%h fl=%b err=%b lat=%0d, want lo=%h hi=%h fl=%b err=%b lat=%0d",
                     i, wid(u), op, a, b, got.lo, got.hi, got.fl, got.err, lat,
                     e.lo, e.hi, e.fl, e.err, exp_lat(u, op));
         end
         // Half the time issue the next op straight from DONE.
         if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      end
   endtask

   task automatic test_hold;
      res_t got, e;
      int lat, extra;
      for (int u = 0; u < 2; u++) begin
         do_op(u, 4'd13, 64'hfff9, 64'h0002, 1'b1, got, lat);
         e = model(wid(u), 4'd13, 64'hfff9, 64'h0002);
         extra = 0;
         repeat (10) begin @(posedge clk); #1; if (dn(u)) extra++; end
         vectors++;
         if (got.lo !== e.lo || got.hi !== e.hi || got.fl !== e.fl || lat != exp_lat(u, 4'd13) || extra != 0) begin
            miscompares++;
            $display("FAIL hold w=%0d: got lo=%h hi=%h fl=%b lat=%0d extra_done=%0d, want lo=%h hi=%h fl=%b lat=%0d extra_done=0",
                     wid(u), got.lo, got.hi, got.fl, lat, extra, e.lo, e.hi, e.fl, exp_lat(u, 4'd13));
         end
      end
   endtask

   task automatic test_back_to_back;
      res_t g1, g2, e1, e2;
      int l1, l2;
      for (int u = 0; u < 2; u++) begin
         do_op(u, 4'd10, 64'hffff, 64'hffff, 1'b0, g1, l1);
         do_op(u, 4'd0, 64'h7fff, 64'h0001, 1'b0, g2, l2);
         e1 = model(wid(u), 4'd10, 64'hffff, 64'hffff);
         e2 = model(wid(u), 4'd0, 64'h7fff, 64'h0001);
         vectors++;
         if (g1.lo !== e1.lo || g1.hi !== e1.hi || l1 != exp_lat(u, 4'd10) ||
             g2.lo !== e2.lo || g2.fl !== e2.fl || l2 != 1) begin
            miscompares++;
            $display("FAIL back_to_back w=%0d: got %h_%h lat%0d then %h fl=%b lat%0d, want %h_%h lat%0d then %h fl=%b lat1",
                     wid(u), g1.hi, g1.lo, l1, g2.lo, g2.fl, l2, e1.hi, e1.lo, exp_lat(u, 4'd10), e2.lo, e2.fl);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid;
      res_t got, e;
      int lat, stray;
      do_op(0, 4'd4, 64'h1234, 64'h00ff, 1'b0, got, lat);
      do_op(1, 4'd5, 64'h0, 64'h0, 1'b0, got, lat);
      drive(0, 1'b1, 4'd11, 64'h1234, 64'h0777);
      drive(1, 1'b1, 4'd13, 64'h12345678, 64'h00000777);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'd0, 64'd0, 64'd0);
      drive(1, 1'b0, 4'd0, 64'd0, 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      vectors++;
      if ({if16.busy, if16.done, if16.err, if16.flags, if16.result_lo, if16.result_hi,
           if32.busy, if32.done, if32.err, if32.flags, if32.result_lo, if32.result_hi} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: lo16=%h hi16=%h fl16=%b busy16=%b lo32=%h hi32=%h fl32=%b busy32=%b, expected all 0",
                  if16.result_lo, if16.result_hi, if16.flags, if16.busy,
                  if32.result_lo, if32.result_hi, if32.flags, if32.busy);
      end
      @(posedge clk); #1 reset = 1'b0;
      stray = 0;
      repeat (8) begin @(posedge clk); #1; if (if16.done || if32.done) stray++; end
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("FAIL reset_mid_no_done: saw %0d done pulses, expected 0", stray);
      end
      for (int u = 0; u < 2; u++) begin
         do_op(u, 4'd11, 64'hfffe, 64'h0003, 1'b0, got, lat);
         e = model(wid(u), 4'd11, 64'hfffe, 64'h0003);
         vectors++;
         if (got.lo !== e.lo || got.hi !== e.hi || got.fl !== e.fl || lat != exp_lat(u, 4'd11)) begin
            miscompares++;
            $display("FAIL after_reset w=%0d: got %h_%h fl=%b lat=%0d, want %h_%h fl=%b lat=%0d",
                     wid(u), got.hi, got.lo, got.fl, lat, e.hi, e.lo, e.fl, exp_lat(u, 4'd11));
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_back_to_back();
      test_random(300);
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
